// File: rtl/rf_pkg.sv
// Phase index constants shared by the register file, instruction decode and controller.
package rf_pkg;

  localparam int PHASE_W = 5;

  // Bit positions within the one-hot phase vector.
  localparam int F = 0;
  localparam int R = 1;
  localparam int X = 2;
  localparam int M = 3;
  localparam int W = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: set on reservation, clear on performed write,
// set wins on collision; answers blk() for the two read addresses.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              clr_fwd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DEPTH-1:0]  pending,
  output logic              blk1,
  output logic              blk2
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;
    assign set_hit = set_en && (set_addr == ADDR_W'(gi));
    assign clr_hit = clr_en && (clr_addr == ADDR_W'(gi));
    assign pend_d[gi] = (ZERO_REG != 0 && gi == 0) ? 1'b0 :
                        set_hit                    ? 1'b1 :
                        clr_hit                    ? 1'b0 : pend_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // A same-cycle write to the read address only unblocks it when its data is forwarded.
  assign blk1 = pend_q[ra1] & ~(clr_fwd & clr_en & (clr_addr == ra1));
  assign blk2 = pend_q[ra2] & ~(clr_fwd & clr_en & (clr_addr == ra2));

  assign pending = pend_q;

endmodule

// File: rtl/rf_regfile_sb.sv
// Parametrised register file with pending scoreboard and single-word debug port.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
module rf_regfile_sb
  import rf_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 3,
  parameter logic [63:0] RESET_VAL = 64'd1,
  parameter int          ZERO_REG  = 0,
  localparam int         DEPTH     = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic [ADDR_W-1:0]  ra1,
  input  logic [ADDR_W-1:0]  ra2,
  output logic [DATA_W-1:0]  rd1,
  output logic [DATA_W-1:0]  rd2,
  input  logic [ADDR_W-1:0]  wa,
  input  logic [DATA_W-1:0]  wd,
  input  logic               we,
  input  logic               res_en,
  input  logic [ADDR_W-1:0]  res_addr,
  output logic [DEPTH-1:0]   pending,
  output logic               hazard,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic              wr_do, rd_do, blk1, blk2;
  logic              unused_phase;

  assign unused_phase = ^{phase[F], phase[X], phase[M]};

  // Writes to the hard-wired zero register are dropped entirely, so they never clear pending.
  assign wr_do = phase[W] & we & ~((ZERO_REG != 0) && (wa == '0));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_V =
      (ZERO_REG != 0 && gi == 0) ? '0 : RESET_VAL[DATA_W-1:0];
    assign mem_d[gi] = rst                                 ? RST_V :
                       (wr_do && (wa == ADDR_W'(gi)))      ? wd    : mem_q[gi];
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (res_en),
    .set_addr (res_addr),
    .clr_en   (wr_do),
    .clr_addr (wa),
    .clr_fwd  (BYPASS),
    .ra1      (ra1),
    .ra2      (ra2),
    .pending  (pending),
    .blk1     (blk1),
    .blk2     (blk2)
  );

  assign hazard = phase[R] & (blk1 | blk2);
  assign rd_do  = phase[R] & ~hazard;

  always_comb begin
    rd1_d = mem_q[ra1];
    rd2_d = mem_q[ra2];
    if (BYPASS && wr_do && (wa == ra1)) rd1_d = wd;
    if (BYPASS && wr_do && (wa == ra2)) rd2_d = wd;
    // Zero register wins over forwarding.
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1_d = '0;
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else if (rd_do) begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign rd1      = rd1_q;
  assign rd2      = rd2_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule
